// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a synchronous ROM and applies branch/halt feedback.
// Optional retired-instruction counter enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter int              INSTR_W    = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Branch,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    BranchTarget,
  input  logic               Halt,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  output logic [PC_W-1:0]    PC,
  output logic               Done,
  output logic [15:0]        InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            exec;
  logic            start_go;

  assign exec     = (state_q == S_RUN) & valid_q & ~Stall;
  assign start_go = (state_q != S_RUN) & Start;

  // The ROM is synchronous, so the address for the next instruction must be
  // presented in the same cycle the current one is executed.
  always_comb begin
    if (state_q != S_RUN) begin
      ImemAddr = START_ADDR;
    end else if (Stall) begin
      ImemAddr = pc_q;
    end else if (exec && Branch && BranchTaken && !Halt) begin
      ImemAddr = BranchTarget;
    end else begin
      ImemAddr = pc_q + PC_W'(1);
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_go) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          valid_d = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (exec) begin
          if (Halt) begin
            state_d = S_HALTED;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            pc_d = ImemAddr;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign Instruction = valid_q ? ImemData : '0;
  assign InstrValid  = valid_q;
  assign PC          = pc_q;
  assign Done        = done_q;

`ifdef FETCH_PERF_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_go) begin
      count_d = '0;
    end else if (exec && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign InstrCount = count_q;
`else
  assign InstrCount = '0;
`endif

endmodule
